// File: rtl/led_pkg.sv
// Shared constants and grant identifiers for the LED write path.
// Used by the arbiter top and the blink timer.
package led_pkg;

    localparam logic [1:0] LED_ADDR_ALL = 2'b00;
    localparam logic [1:0] LED_ADDR_BAD = 2'b01;
    localparam logic [1:0] LED_ADDR_HI  = 2'b10;
    localparam logic [1:0] LED_ADDR_LO  = 2'b11;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2,
        GNT_BLK  = 2'd3
    } grant_e;

    // Address 01 has no LED bank behind it; such writes are acked but dropped.
    function automatic logic addr_legal(input logic [1:0] addr);
        return addr != LED_ADDR_BAD;
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period counter with a single-entry pending flag and ON/OFF phase.
// The arbiter raises serve when it issues the blink write.
module led_blink_timer
    import led_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int CNT_W     = 25
) (
    input  logic led_clk,
    input  logic ledrst,
    input  logic blink_en,
    input  logic serve,
    output logic pending,
    output logic phase_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             wrap;

    assign wrap       = blink_en && (cnt == CNT_MAX);
    assign phase_next = ~phase;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            cnt     <= '0;
            pending <= 1'b0;
            phase   <= 1'b0;
        end else if (!blink_en) begin
            cnt     <= '0;
            pending <= 1'b0;
            phase   <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            // A wrap wins over a same-cycle service so the new half-period is not lost.
            if (wrap)
                pending <= 1'b1;
            else if (serve)
                pending <= 1'b0;
            if (serve)
                phase <= ~phase;
        end
    end

endmodule

// File: rtl/led_write_arbiter.sv
// Arbitrates CPU, debug and blink writes onto the single LED register write port.
// Round-robin between CPU and debug; blink only fills otherwise idle cycles.
module led_write_arbiter
    import led_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int CNT_W     = 25
) (
    input  logic        led_clk,
    input  logic        ledrst,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic [1:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    input  logic        blink_en,
    input  logic [7:0]  blink_pat,
    output logic        led_ctrl,
    output logic [1:0]  led_addr,
    output logic [31:0] led_wdata
);

    logic   rr_dbg;         // 1: debug wins the next CPU/debug tie
    logic   cpu_elig;
    logic   dbg_elig;
    logic   blink_pending;
    logic   blink_phase_next;
    logic   serve;
    grant_e grant;

    // A requester whose ack is already out is still holding req from the last grant.
    assign cpu_elig = cpu_req && !cpu_ack;
    assign dbg_elig = dbg_req && !dbg_ack;
    assign serve    = (grant == GNT_BLK);

    // NOTE: default assigned first so no path leaves grant unassigned (no latch).
    always_comb begin
        grant = GNT_NONE;
        if (cpu_elig && dbg_elig)
            grant = rr_dbg ? GNT_DBG : GNT_CPU;
        else if (cpu_elig)
            grant = GNT_CPU;
        else if (dbg_elig)
            grant = GNT_DBG;
        else if (blink_en && blink_pending)
            grant = GNT_BLK;
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            rr_dbg    <= 1'b0;
            led_ctrl  <= 1'b0;
            led_addr  <= LED_ADDR_ALL;
            led_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
        end else begin
            led_ctrl <= 1'b0;
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            unique case (grant)
                GNT_CPU: begin
                    cpu_ack <= 1'b1;
                    rr_dbg  <= 1'b1;
                    if (addr_legal(cpu_addr)) begin
                        led_ctrl  <= 1'b1;
                        led_addr  <= cpu_addr;
                        led_wdata <= cpu_wdata;
                    end
                end
                GNT_DBG: begin
                    dbg_ack <= 1'b1;
                    rr_dbg  <= 1'b0;
                    if (addr_legal(dbg_addr)) begin
                        led_ctrl  <= 1'b1;
                        led_addr  <= dbg_addr;
                        led_wdata <= dbg_wdata;
                    end
                end
                GNT_BLK: begin
                    led_ctrl  <= 1'b1;
                    led_addr  <= LED_ADDR_HI;
                    led_wdata <= {24'h0, blink_phase_next ? blink_pat : 8'h00};
                end
                default: ;
            endcase
        end
    end

    led_blink_timer #(
        .BLINK_DIV (BLINK_DIV),
        .CNT_W     (CNT_W)
    ) u_blink (
        .led_clk    (led_clk),
        .ledrst     (ledrst),
        .blink_en   (blink_en),
        .serve      (serve),
        .pending    (blink_pending),
        .phase_next (blink_phase_next)
    );

endmodule

// File: tb/tb_led_write_arbiter.sv
// Directed bench for led_write_arbiter with a short blink period.
module tb_led_write_arbiter;

    logic        led_clk;
    logic        ledrst;
    logic        cpu_req;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        dbg_req;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic        blink_en;
    logic [7:0]  blink_pat;
    logic        led_ctrl;
    logic [1:0]  led_addr;
    logic [31:0] led_wdata;

    int checks = 0;
    int errors = 0;

    led_write_arbiter #(
        .BLINK_DIV (4),
        .CNT_W     (2)
    ) dut (
        .led_clk   (led_clk),
        .ledrst    (ledrst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .blink_en  (blink_en),
        .blink_pat (blink_pat),
        .led_ctrl  (led_ctrl),
        .led_addr  (led_addr),
        .led_wdata (led_wdata)
    );

    initial led_clk = 1'b0;
    always #5 led_clk = ~led_clk;

    // {ctrl, addr, wdata, cpu_ack, dbg_ack}
    function automatic logic [36:0] obs_vec();
        return {led_ctrl, led_addr, led_wdata, cpu_ack, dbg_ack};
    endfunction

    task automatic step();
        @(posedge led_clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        ledrst = 1'b1;
        step();
        ledrst = 1'b0;
    endtask

    task automatic test_reset();
        ledrst = 1'b1;
        repeat (2) step();
        checks++;
        if (obs_vec() !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 37'h0);
        end
        ledrst = 1'b0;
    endtask

    task automatic test_cpu_only();
        logic [36:0] exp;
        cpu_req = 1'b1; cpu_addr = 2'b00; cpu_wdata = 32'h0000_A5A5;
        step();
        exp = {1'b1, 2'b00, 32'h0000_A5A5, 1'b1, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL cpu_only_write got=%h want=%h", obs_vec(), exp);
        end
        // Requester still holds req during the ack cycle: must not be reissued.
        step();
        exp = {1'b0, 2'b00, 32'h0000_A5A5, 1'b0, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL cpu_only_no_second got=%h want=%h", obs_vec(), exp);
        end
        cpu_req = 1'b0;
        step();
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL cpu_only_idle got=%h want=%h", obs_vec(), exp);
        end
    endtask

    task automatic test_contention();
        logic [36:0] exp;
        do_reset();
        cpu_addr = 2'b00; cpu_wdata = 32'h0000_1111;
        dbg_addr = 2'b11; dbg_wdata = 32'h0000_2222;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i % 2 == 0) ? {1'b1, 2'b00, 32'h0000_1111, 1'b1, 1'b0}
                               : {1'b1, 2'b11, 32'h0000_2222, 1'b0, 1'b1};
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL contention_grant%0d got=%h want=%h", i, obs_vec(), exp);
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        exp = {1'b0, 2'b11, 32'h0000_2222, 1'b0, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL contention_idle got=%h want=%h", obs_vec(), exp);
        end
    endtask

    task automatic test_illegal();
        logic [36:0] exp;
        dbg_req = 1'b1; dbg_addr = 2'b01; dbg_wdata = 32'h0000_3333;
        step();
        checks++;
        if ({led_ctrl, cpu_ack, dbg_ack} !== 3'b001) begin
            errors++;
            $display("FAIL illegal_dropped got=%b want=%b", {led_ctrl, cpu_ack, dbg_ack}, 3'b001);
        end
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_addr = 2'b10; cpu_wdata = 32'h0000_00AB;
        step();
        exp = {1'b1, 2'b10, 32'h0000_00AB, 1'b1, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL illegal_then_cpu got=%h want=%h", obs_vec(), exp);
        end
        cpu_req = 1'b0;
        step();
        exp = {1'b0, 2'b10, 32'h0000_00AB, 1'b0, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL illegal_idle got=%h want=%h", obs_vec(), exp);
        end
    endtask

    task automatic test_blink();
        logic [36:0] exp;
        do_reset();
        blink_pat = 8'h3C;
        blink_en  = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 5 || i == 9 || i == 13) begin
                exp = {1'b1, 2'b10, (i == 9) ? 32'h0000_0000 : 32'h0000_003C, 1'b0, 1'b0};
                checks++;
                if (obs_vec() !== exp) begin
                    errors++;
                    $display("FAIL blink_pulse_c%0d got=%h want=%h", i, obs_vec(), exp);
                end
            end else begin
                checks++;
                if (led_ctrl !== 1'b0) begin
                    errors++;
                    $display("FAIL blink_gap_c%0d got=%b want=0", i, led_ctrl);
                end
            end
        end
        blink_en = 1'b0;
        repeat (6) begin
            step();
            checks++;
            if (led_ctrl !== 1'b0) begin
                errors++;
                $display("FAIL blink_disabled got=%b want=0", led_ctrl);
            end
        end
    endtask

    task automatic test_starve();
        logic [36:0] exp;
        logic [2:0]  exp3;
        do_reset();
        blink_pat = 8'h3C;
        cpu_addr = 2'b00; cpu_wdata = 32'h0000_1111;
        dbg_addr = 2'b11; dbg_wdata = 32'h0000_2222;
        blink_en = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        // Three blink wraps occur while some requester is eligible every cycle.
        for (int i = 1; i <= 14; i++) begin
            step();
            exp3 = (i % 2 == 1) ? 3'b110 : 3'b101;
            checks++;
            if ({led_ctrl, cpu_ack, dbg_ack} !== exp3) begin
                errors++;
                $display("FAIL starve_c%0d got=%b want=%b", i, {led_ctrl, cpu_ack, dbg_ack}, exp3);
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        exp = {1'b1, 2'b10, 32'h0000_003C, 1'b0, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL starve_blink_once got=%h want=%h", obs_vec(), exp);
        end
        blink_en = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (led_ctrl !== 1'b0) begin
                errors++;
                $display("FAIL starve_no_extra got=%b want=0", led_ctrl);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] exp;
        do_reset();
        cpu_req = 1'b1; cpu_addr = 2'b00; cpu_wdata = 32'h0000_5A5A;
        step();
        exp = {1'b1, 2'b00, 32'h0000_5A5A, 1'b1, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL rstmid_write got=%h want=%h", obs_vec(), exp);
        end
        ledrst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 37'h0) begin
            errors++;
            $display("FAIL rstmid_async_clear got=%h want=%h", obs_vec(), 37'h0);
        end
        step();
        ledrst = 1'b0;
        step();
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL rstmid_reissue got=%h want=%h", obs_vec(), exp);
        end
        cpu_req = 1'b0;
        step();
        exp = {1'b0, 2'b00, 32'h0000_5A5A, 1'b0, 1'b0};
        checks++;
        if (obs_vec() !== exp) begin
            errors++;
            $display("FAIL rstmid_idle got=%h want=%h", obs_vec(), exp);
        end
    endtask

    initial begin
        ledrst = 1'b1;
        cpu_req = 1'b0; cpu_addr = 2'b00; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_addr = 2'b00; dbg_wdata = '0;
        blink_en = 1'b0; blink_pat = 8'h00;
        test_reset();
        test_cpu_only();
        test_contention();
        test_illegal();
        test_blink();
        test_starve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
